// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one full-subtractor cell per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Full-subtractor cell, returns {borrow_out, difference}.
    function automatic logic [1:0] fs_cell(input logic ai, input logic bi, input logic bri);
        logic d_v;
        logic br_v;
        d_v  = ai ^ bi ^ bri;
        br_v = (~ai & bi) | (~(ai ^ bi) & bri);
        fs_cell = {br_v, d_v};
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [WIDTH-1:0] a_sh_r, a_sh_s;
    logic [WIDTH-1:0] b_sh_r, b_sh_s;
    logic             br_r, br_s;
    logic [WIDTH-2:0] res_r, res_s;
    logic [WIDTH-1:0] diff_r, diff_s;
    logic             bout_r, bout_s;
    logic             done_r, done_s;
    logic             busy_r, busy_s;
    logic [1:0]       cell_s;
    logic [WIDTH-1:0] full_s;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_r, a_msb_s;
    logic             b_msb_r, b_msb_s;
    logic             ovf_r, ovf_s;
`endif

    // Next-state and datapath decode for the IDLE/RUN controller.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        a_sh_s  = a_sh_r;
        b_sh_s  = b_sh_r;
        br_s    = br_r;
        res_s   = res_r;
        diff_s  = diff_r;
        bout_s  = bout_r;
        done_s  = 1'b0;
        cell_s  = fs_cell(a_sh_r[0], b_sh_r[0], br_r);
        // Result bits enter from the MSB side; on the last bit this is the whole word.
        full_s  = {cell_s[0], res_r};
`ifdef SERIAL_SUB_OVF_EN
        a_msb_s = a_msb_r;
        b_msb_s = b_msb_r;
        ovf_s   = ovf_r;
`endif
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                    cnt_s   = '0;
                    a_sh_s  = a;
                    b_sh_s  = b;
                    br_s    = bin;
                    res_s   = '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_s = a[WIDTH-1];
                    b_msb_s = b[WIDTH-1];
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                a_sh_s = {1'b0, a_sh_r[WIDTH-1:1]};
                b_sh_s = {1'b0, b_sh_r[WIDTH-1:1]};
                br_s   = cell_s[1];
                res_s  = full_s[WIDTH-1:1];
                if (cnt_r == LAST) begin
                    state_s = IDLE;
                    cnt_s   = '0;
                    done_s  = 1'b1;
                    diff_s  = full_s;
                    bout_s  = cell_s[1];
`ifdef SERIAL_SUB_OVF_EN
                    ovf_s   = (a_msb_r != b_msb_r) && (full_s[WIDTH-1] != a_msb_r);
`endif
                end else begin
                    cnt_s = cnt_r + 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
        busy_s = (state_s == RUN);
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            br_r    <= 1'b0;
            res_r   <= '0;
            diff_r  <= '0;
            bout_r  <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            ovf_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            a_sh_r  <= a_sh_s;
            b_sh_r  <= b_sh_s;
            br_r    <= br_s;
            res_r   <= res_s;
            diff_r  <= diff_s;
            bout_r  <= bout_s;
            done_r  <= done_s;
            busy_r  <= busy_s;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_r <= a_msb_s;
            b_msb_r <= b_msb_s;
            ovf_r   <= ovf_s;
`endif
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign diff = diff_r;
    assign bout = bout_r;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4); checks ovf when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard entries are {ovf, bout, diff}.
    logic [WIDTH+1:0] sb[$];
    logic             m_init = 1'b0;
    logic             m_busy = 1'b0;
    logic             m_done = 1'b0;
    int               m_cnt  = 0;
    logic [WIDTH-1:0] m_diff = '0;
    logic             m_bout = 1'b0;
    logic             m_ovf  = 1'b0;
    int               done_cnt = 0;

    // Reference timing model: pushes expectations on accept, pops them at completion.
    always @(posedge clk) begin
        logic [WIDTH:0]   r;
        logic [WIDTH+1:0] e;
        logic             o;
        if (!rst_n) begin
            m_init = 1'b1;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_cnt  = 0;
            m_diff = '0;
            m_bout = 1'b0;
            m_ovf  = 1'b0;
            sb.delete();
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    r = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
                    o = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
                    sb.push_back({o, r[WIDTH], r[WIDTH-1:0]});
                    m_busy = 1'b1;
                    m_cnt  = 0;
                end
            end else begin
                m_cnt++;
                if (m_cnt == WIDTH) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    e      = sb.pop_front();
                    m_diff = e[WIDTH-1:0];
                    m_bout = e[WIDTH];
                    m_ovf  = e[WIDTH+1];
                end
            end
        end
    end

    // Cycle-by-cycle comparison away from the active edge.
    always @(negedge clk) begin
        if (m_init) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("diff", diff, m_diff);
            chk("bout", bout, m_bout);
`ifdef SERIAL_SUB_OVF_EN
            chk("ovf", ovf, m_ovf);
`endif
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bi);
        @(negedge clk);
        start = 1'b1; a = av; b = bv; bin = bi;
        @(negedge clk);
        start = 1'b0;
        repeat (WIDTH + 1) @(negedge clk);
        #1;
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_diff", diff, 4'd0);
        chk("rst_bout", bout, 1'b0);
        rst_n = 1'b1;

        run_op(4'd9, 4'd3, 1'b0);
        chk("d_9_3", diff, 4'd6);
        chk("b_9_3", bout, 1'b0);
        run_op(4'd3, 4'd9, 1'b0);
        chk("d_3_9", diff, 4'd10);
        chk("b_3_9", bout, 1'b1);
        run_op(4'd0, 4'd0, 1'b1);
        chk("d_0_0_1", diff, 4'hF);
        chk("b_0_0_1", bout, 1'b1);
        run_op(4'd15, 4'd15, 1'b0);
        chk("d_15_15", diff, 4'd0);

        // start while busy must be ignored
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; a = 4'd9; b = 4'd3; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 4'd15; b = 4'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (WIDTH + 1) @(negedge clk);
        #1;
        chk("ign_diff", diff, 4'd6);
        chk("ign_done_cnt", done_cnt - d0, 1);

        // back-to-back with start held high: three full periods
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; a = 4'd5; b = 4'd2; bin = 1'b0;
        repeat (3 * (WIDTH + 1)) @(negedge clk);
        start = 1'b0;
        repeat (WIDTH + 2) @(negedge clk);
        #1;
        chk("b2b_done_cnt", done_cnt - d0, 3);
        chk("b2b_diff", diff, 4'd3);

        // reset mid-run after two bits
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; a = 4'd12; b = 4'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_diff", diff, 4'd0);
        chk("mid_rst_bout", bout, 1'b0);
        rst_n = 1'b1;
        repeat (WIDTH + 2) @(negedge clk);
        #1;
        chk("mid_rst_no_done", done_cnt - d0, 0);
        run_op(4'd12, 4'd4, 1'b0);
        chk("d_12_4", diff, 4'd8);

        run_op(4'b0111, 4'b1000, 1'b0);
        chk("d_7_8", diff, 4'b1111);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf_7_8", ovf, 1'b1);
`endif
        run_op(4'd5, 4'd2, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf_5_2", ovf, 1'b0);
`endif
        chk("d_5_2", diff, 4'd3);

        for (int i = 0; i < 8; i++) begin
            run_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b - bin, LSB first, one bit per clock, through a single full-subtractor cell and a registered borrow.
- Area-lean counterpart to the parallel ripple adder chain; used where an operand pair arrives occasionally and latency is acceptable.
- start/busy/done handshake; results held until the next completion.

Parameters:
- WIDTH, 4, operand/result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only when idle.
- a  input  WIDTH  minuend, captured on accepted start.
- b  input  WIDTH  subtrahend, captured on accepted start.
- bin  input  1  borrow-in, captured on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.
- diff  output  WIDTH  difference, registered.
- bout  output  1  borrow-out of the MSB stage, registered.

Behaviour:
- Reset:
  - Clock and reset: one clock (clk), synchronous active-low reset (rst_n). Reset is sampled only on the rising clk edge.
  - While rst_n=0 at an edge: state=IDLE, busy=0, done=0, diff=0, bout=0, bit counter=0, internal shift registers and borrow cleared.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE -> RUN:
  - Occurs at the edge where start=1 (edge E0).
  - Latches a, b and bin. Clears the counter. busy=1 from E0.
- RUN, edge Ek, k=1..WIDTH, processes bit i=k-1:
  - d_i = a_i ^ b_i ^ br.
  - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
  - d_i shifts into the result register from the MSB side. The operand registers shift right.
- Completion at edge E_WIDTH:
  - diff is loaded with the full result and bout with the final borrow, in the same edge. Partial results never appear on diff.
  - done=1 for exactly the cycle after E_WIDTH. State returns to IDLE and busy=0 in that same cycle.
  - Latency: start accepted -> done high = WIDTH clock edges.
- Arithmetic:
  - Unsigned modulo 2^WIDTH.
  - bout=1 iff a < b + bin, treating the operands as unsigned.
- start while busy=1 is ignored. Operands are not re-latched and the in-flight result is unaffected.
- start=1 in the done cycle: state is IDLE, so it is accepted (back-to-back). done still pulses for exactly one cycle.
- diff and bout hold their last value until the next completion or reset. a, b and bin may change freely after acceptance.
- Reset mid-operation: the operation is aborted, all outputs are zero at the next edge, and no done pulse follows.
- start held high continuously: a new operation starts every WIDTH+1 cycles.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), a registered signed two's-complement overflow flag updated with diff.
  - ovf = (a_msb != b_msb) && (diff_msb != a_msb), using the latched operand MSBs.
  - Reset value 0. Holds like diff.
- Not defined: the ovf port and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=4; a=9, b=3, bin=0, start pulse -> busy for 4 cycles; done pulse 4 edges after accept; diff=6, bout=0.
- a=3, b=9, bin=0 -> diff=4'b1010 (10), bout=1. Then a=0, b=0, bin=1 -> diff=4'hF, bout=1.
- Assert start with new operands (a=15, b=1) two cycles into a run of 9-3 -> ignored; result diff=6; exactly one done pulse.
- Back-to-back: start held high with a=5, b=2 -> done every 5 cycles; diff=3 each time; busy low only in the done cycles.
- rst_n=0 for one edge mid-run (after 2 bits) -> busy=0, diff=0, bout=0, no done pulse. A following 12-4 run yields diff=8.
- With SERIAL_SUB_OVF_EN:
  - a=4'b0111, b=4'b1000 -> diff=4'b1111, ovf=1.
  - a=5, b=2 -> ovf=0.
  - Compile without the macro and confirm the bench builds without ovf.
